// File: rtl/pixel_stream_gen.sv
// Raster timing generator with a byte-unpacking framebuffer stream front end.
// The unpack buffer is realigned (flushed) once per frame so every frame starts on a word boundary.
module pixel_stream_gen #(
  parameter int   H_ACTIVE  = 640,
  parameter int   H_FP      = 16,
  parameter int   H_SYNC    = 96,
  parameter int   H_BP      = 48,
  parameter int   V_ACTIVE  = 480,
  parameter int   V_FP      = 10,
  parameter int   V_SYNC    = 2,
  parameter int   V_BP      = 33,
  parameter logic HSYNC_POL = 1'b0,
  parameter logic VSYNC_POL = 1'b0
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        enable_i,
  input  logic [1:0]  bpp_mode_i,
  input  logic [31:0] word_data_i,
  input  logic        word_valid_i,
  output logic        word_ready_o,
  output logic        hsync_o,
  output logic        vsync_o,
  output logic        de_o,
  output logic [7:0]  red_o,
  output logic [7:0]  green_o,
  output logic [7:0]  blue_o,
  output logic        frame_start_o,
  output logic        underflow_o,
  input  logic        underflow_clr_i
);
  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int XW = $clog2(H_TOTAL + 1);
  localparam int YW = $clog2(V_TOTAL + 1);

  localparam logic [XW-1:0] X_LAST = XW'(H_TOTAL - 1);
  localparam logic [XW-1:0] X_ACT  = XW'(H_ACTIVE);
  localparam logic [XW-1:0] X_HS0  = XW'(H_ACTIVE + H_FP);
  localparam logic [XW-1:0] X_HS1  = XW'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [YW-1:0] Y_LAST = YW'(V_TOTAL - 1);
  localparam logic [YW-1:0] Y_ACT  = YW'(V_ACTIVE);
  localparam logic [YW-1:0] Y_VS0  = YW'(V_ACTIVE + V_FP);
  localparam logic [YW-1:0] Y_VS1  = YW'(V_ACTIVE + V_FP + V_SYNC);

  logic [XW-1:0] r_x;
  logic [YW-1:0] r_y;
  logic [63:0]   r_buf;
  logic [3:0]    r_fill;
  logic [1:0]    r_mode;
  logic          r_de, r_hs, r_vs, r_fs, r_uf;
  logic [7:0]    r_red, r_green, r_blue;

  logic          w_active, w_hs, w_vs, w_flush, w_frame0;
  logic [3:0]    w_bpp, w_used, w_fill_after, w_fill_next;
  logic          w_starve, w_consume, w_ready, w_accept;
  logic [63:0]   w_buf_next;
  logic [7:0]    w_b0, w_b1, w_b2;
  logic [15:0]   w_hw;
  logic [7:0]    w_red, w_green, w_blue;

  assign w_active  = (r_x < X_ACT) && (r_y < Y_ACT);
  assign w_hs      = (r_x >= X_HS0) && (r_x < X_HS1);
  assign w_vs      = (r_y >= Y_VS0) && (r_y < Y_VS1);
  assign w_flush   = (r_x == '0) && (r_y == Y_ACT);
  assign w_frame0  = (r_x == '0) && (r_y == '0);

  assign w_bpp     = {2'b00, r_mode} + 4'd1;
  assign w_starve  = w_active && (r_fill < w_bpp);
  assign w_consume = w_active && !w_starve;
  assign w_ready   = enable_i && !rst_i && (r_fill <= 4'd4) && !w_flush;
  assign w_accept  = w_ready && word_valid_i;

  // Bytes at or above fill are always zero, so a new word can simply be OR-ed in above the survivors.
  assign w_used       = w_consume ? w_bpp : 4'd0;
  assign w_fill_after = r_fill - w_used;
  assign w_fill_next  = w_fill_after + (w_accept ? 4'd4 : 4'd0);

  always_comb begin
    w_buf_next = r_buf >> {w_used, 3'b000};
    if (w_accept) begin
      w_buf_next = w_buf_next | ({32'b0, word_data_i} << {w_fill_after, 3'b000});
    end
  end

  assign w_b0 = r_buf[7:0];
  assign w_b1 = r_buf[15:8];
  assign w_b2 = r_buf[23:16];
  assign w_hw = {w_b1, w_b0};

  always_comb begin
    w_red   = w_b0;
    w_green = w_b1;
    w_blue  = w_b2;
    case (r_mode)
      2'd0: begin
        w_green = w_b0;
        w_blue  = w_b0;
      end
      2'd1: begin
        w_red   = {w_hw[15:11], w_hw[15:13]};
        w_green = {w_hw[10:5],  w_hw[10:9]};
        w_blue  = {w_hw[4:0],   w_hw[4:2]};
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_x     <= '0;
      r_y     <= '0;
      r_buf   <= '0;
      r_fill  <= '0;
      r_mode  <= 2'd2;
      r_de    <= 1'b0;
      r_hs    <= ~HSYNC_POL;
      r_vs    <= ~VSYNC_POL;
      r_fs    <= 1'b0;
      r_uf    <= 1'b0;
      r_red   <= '0;
      r_green <= '0;
      r_blue  <= '0;
    end else if (!enable_i) begin
      r_x     <= '0;
      r_y     <= '0;
      r_buf   <= '0;
      r_fill  <= '0;
      r_mode  <= bpp_mode_i;
      r_de    <= 1'b0;
      r_hs    <= ~HSYNC_POL;
      r_vs    <= ~VSYNC_POL;
      r_fs    <= 1'b0;
      r_uf    <= r_uf & ~underflow_clr_i;
      r_red   <= '0;
      r_green <= '0;
      r_blue  <= '0;
    end else begin
      if (r_x == X_LAST) begin
        r_x <= '0;
        r_y <= (r_y == Y_LAST) ? '0 : r_y + 1'b1;
      end else begin
        r_x <= r_x + 1'b1;
      end
      if (w_flush) begin
        r_buf  <= '0;
        r_fill <= '0;
        r_mode <= bpp_mode_i;
      end else begin
        r_buf  <= w_buf_next;
        r_fill <= w_fill_next;
      end
      r_de    <= w_active;
      r_hs    <= w_hs ? HSYNC_POL : ~HSYNC_POL;
      r_vs    <= w_vs ? VSYNC_POL : ~VSYNC_POL;
      r_fs    <= w_frame0;
      r_uf    <= w_starve | (r_uf & ~underflow_clr_i);
      r_red   <= w_consume ? w_red   : 8'd0;
      r_green <= w_consume ? w_green : 8'd0;
      r_blue  <= w_consume ? w_blue  : 8'd0;
    end
  end

  assign word_ready_o  = w_ready;
  assign de_o          = r_de;
  assign hsync_o       = r_hs;
  assign vsync_o       = r_vs;
  assign frame_start_o = r_fs;
  assign underflow_o   = r_uf;
  assign red_o         = r_red;
  assign green_o       = r_green;
  assign blue_o        = r_blue;
endmodule

// File: tb/tb_pixel_stream_gen.sv
// Bench for pixel_stream_gen on a tiny 7x5 raster: a byte-queue reference model predicts every
// registered output cycle; a monitor pops and compares. word_ready_o is checked combinationally.
module tb_pixel_stream_gen;
  localparam int HA = 4, HF = 1, HS = 1, HB = 1;
  localparam int VA = 2, VF = 1, VS = 1, VB = 1;
  localparam int HT = HA + HF + HS + HB;
  localparam int VT = VA + VF + VS + VB;
  localparam int FT = HT * VT;

  logic        clk;
  logic        rst_i, enable_i, word_valid_i, underflow_clr_i;
  logic [1:0]  bpp_mode_i;
  logic [31:0] word_data_i;
  logic        word_ready_o, hsync_o, vsync_o, de_o, frame_start_o, underflow_o;
  logic [7:0]  red_o, green_o, blue_o;

  pixel_stream_gen #(
    .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
    .HSYNC_POL(1'b0), .VSYNC_POL(1'b0)
  ) dut (
    .clk_i(clk), .rst_i(rst_i), .enable_i(enable_i), .bpp_mode_i(bpp_mode_i),
    .word_data_i(word_data_i), .word_valid_i(word_valid_i), .word_ready_o(word_ready_o),
    .hsync_o(hsync_o), .vsync_o(vsync_o), .de_o(de_o),
    .red_o(red_o), .green_o(green_o), .blue_o(blue_o),
    .frame_start_o(frame_start_o), .underflow_o(underflow_o), .underflow_clr_i(underflow_clr_i)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // scoreboard
  logic [28:0] exp_q[$];
  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
  endtask

  // reference model: frame position from cycle index, buffer as a plain byte queue
  int         m_t = 0;
  logic [7:0] m_bytes[$];
  logic [1:0] m_mode = 2'd2;
  logic       m_uf = 1'b0;

  function automatic logic [28:0] pack(input logic de, hs_l, vs_l, fs, uf,
                                       input logic [7:0] r, g, b);
    return {de, hs_l, vs_l, fs, uf, r, g, b};
  endfunction

  function automatic logic model_ready();
    int x, y;
    if (rst_i || !enable_i) return 1'b0;
    x = m_t % HT;
    y = m_t / HT;
    return (m_bytes.size() <= 4) && !(x == 0 && y == VA);
  endfunction

  task automatic model_step();
    int x, y, need;
    logic active, hs_a, vs_a, set, rdy;
    logic [7:0] px[4];
    logic [7:0] r, g, b, c5, c6;
    logic [15:0] hw;
    if (rst_i) begin
      m_bytes.delete(); m_t = 0; m_mode = 2'd2; m_uf = 1'b0;
      exp_q.push_back(pack(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 8'd0, 8'd0, 8'd0));
      return;
    end
    if (!enable_i) begin
      m_bytes.delete(); m_t = 0; m_mode = bpp_mode_i;
      if (underflow_clr_i) m_uf = 1'b0;
      exp_q.push_back(pack(1'b0, 1'b1, 1'b1, 1'b0, m_uf, 8'd0, 8'd0, 8'd0));
      return;
    end
    x = m_t % HT;
    y = m_t / HT;
    active = (x < HA) && (y < VA);
    hs_a = (x >= HA + HF) && (x < HA + HF + HS);
    vs_a = (y >= VA + VF) && (y < VA + VF + VS);
    rdy = model_ready();
    r = 8'd0; g = 8'd0; b = 8'd0; set = 1'b0;
    if (active) begin
      need = int'(m_mode) + 1;
      if (m_bytes.size() >= need) begin
        for (int i = 0; i < 4; i++) px[i] = 8'd0;
        for (int i = 0; i < need; i++) px[i] = m_bytes.pop_front();
        case (m_mode)
          2'd0: begin r = px[0]; g = px[0]; b = px[0]; end
          2'd1: begin
            hw = {px[1], px[0]};
            c5 = 8'(hw >> 11);       r = (c5 << 3) | (c5 >> 2);
            c6 = 8'((hw >> 5) & 63); g = (c6 << 2) | (c6 >> 4);
            c5 = 8'(hw & 31);        b = (c5 << 3) | (c5 >> 2);
          end
          default: begin r = px[0]; g = px[1]; b = px[2]; end
        endcase
      end else begin
        set = 1'b1;
      end
    end
    if (rdy && word_valid_i)
      for (int i = 0; i < 4; i++) m_bytes.push_back(8'(word_data_i >> (8 * i)));
    if (x == 0 && y == VA) begin
      m_bytes.delete();
      m_mode = bpp_mode_i;
    end
    m_uf = set | (m_uf & !underflow_clr_i);
    exp_q.push_back(pack(active, !hs_a, !vs_a, m_t == 0, m_uf, r, g, b));
    m_t = (m_t + 1) % FT;
  endtask

  // driver: one clock cycle of stimulus, checks ready and feeds the model
  task automatic cycle(input logic rst, en, input logic [1:0] mode, input logic [31:0] data,
                       input logic valid, clr, output logic acc);
    @(negedge clk);
    rst_i = rst; enable_i = en; bpp_mode_i = mode;
    word_data_i = data; word_valid_i = valid; underflow_clr_i = clr;
    #1;
    acc = model_ready() && valid;
    check("word_ready", {31'd0, word_ready_o}, {31'd0, model_ready()});
    model_step();
  endtask

  // monitor
  initial begin
    logic [28:0] e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("pixel_out",
              {3'd0, de_o, hsync_o, vsync_o, frame_start_o, underflow_o, red_o, green_o, blue_o},
              {3'd0, e});
      end
    end
  end

  // stimulus
  initial begin
    logic acc;
    logic [7:0] k;
    logic [1:0] mode;
    logic en;
    rst_i = 1'b1; enable_i = 1'b0; bpp_mode_i = 2'd2;
    word_data_i = '0; word_valid_i = 1'b0; underflow_clr_i = 1'b0;
    repeat (3) cycle(1'b1, 1'b0, 2'd2, 32'd0, 1'b0, 1'b0, acc);

    // mode 2 with a byte-counting stream; reset lands on x=1 of the second frame (fill 5)
    k = 8'd0;
    for (int i = 0; i < FT + 1; i++) begin
      cycle(1'b0, 1'b1, 2'd2, {k + 8'd3, k + 8'd2, k + 8'd1, k}, 1'b1, 1'b0, acc);
      if (acc) k = k + 8'd4;
    end
    cycle(1'b1, 1'b1, 2'd2, 32'hDEADBEEF, 1'b1, 1'b0, acc);
    k = 8'd0;
    for (int i = 0; i < 2 * FT; i++) begin
      cycle(1'b0, 1'b1, 2'd2, {k + 8'd3, k + 8'd2, k + 8'd1, k}, 1'b1, 1'b0, acc);
      if (acc) k = k + 8'd4;
    end

    // RGB565 via a disabled gap, then starvation and clear
    repeat (2) cycle(1'b0, 1'b0, 2'd1, 32'd0, 1'b0, 1'b0, acc);
    for (int i = 0; i < 2 * FT; i++) cycle(1'b0, 1'b1, 2'd0, 32'h001FF800, 1'b1, 1'b0, acc);
    for (int i = 0; i < 10; i++) cycle(1'b0, 1'b1, 2'd0, 32'h001FF800, 1'b0, 1'b0, acc);
    for (int i = 0; i < FT; i++) cycle(1'b0, 1'b1, 2'd0, 32'h001FF800, 1'b1, 1'b0, acc);
    cycle(1'b0, 1'b1, 2'd0, 32'h001FF800, 1'b1, 1'b1, acc);
    for (int i = 0; i < 10; i++) cycle(1'b0, 1'b1, 2'd0, 32'h001FF800, 1'b1, 1'b0, acc);

    // mode 2 -> 0 mid-frame
    repeat (2) cycle(1'b0, 1'b0, 2'd2, 32'd0, 1'b0, 1'b1, acc);
    k = 8'd0;
    for (int i = 0; i < 3 * FT; i++) begin
      mode = (i < 10) ? 2'd2 : 2'd0;
      cycle(1'b0, 1'b1, mode, {k + 8'd3, k + 8'd2, k + 8'd1, k}, 1'b1, 1'b0, acc);
      if (acc) k = k + 8'd4;
    end

    // randomized traffic
    mode = 2'd3;
    en = 1'b1;
    for (int i = 0; i < 2000; i++) begin
      if ($urandom_range(0, 59) == 0) mode = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 149) == 0) en = ~en;
      if (!en && $urandom_range(0, 3) == 0) en = 1'b1;
      cycle($urandom_range(0, 299) == 0, en, mode, $urandom,
            $urandom_range(0, 9) < 8, $urandom_range(0, 29) == 0, acc);
    end

    @(posedge clk);
    #2;
    check("queue_drained", exp_q.size(), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
